// File: rtl/mmio_bridge.sv
// mmio_bridge
// Data-side responder for the CPU MEM-stage port. Each word access is
// routed either to the external data RAM or to a 4 KiB page of board
// peripherals at 0xFFFFF000: DISP (0x000), TIMER (0x020), LED (0x060),
// SW (0x070). Loads are answered combinationally in the same cycle.
// The block also scans the eight-digit seven-segment display and
// synchronizes the asynchronous board switches.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   dram_we         : CPU store strobe
//   addr            : CPU byte address (bits [1:0] ignored)
//   write_data      : CPU store data
//   read_data       : load data back to CPU (combinational)
//   ram_we/addr/wdata/rdata : data RAM port (async read)
//   sw              : board switches (asynchronous)
//   led             : board LEDs (registered)
//   dig_en          : digit enables, active-low one-hot
//   seg             : segments {dp,g,f,e,d,c,b,a}, active-low

module mmio_bridge #(
    parameter int RAM_AW   = 14,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dram_we,
    input  logic [31:0]       addr,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [23:0]       sw,
    output logic [23:0]       led,
    output logic [7:0]        dig_en,
    output logic [7:0]        seg
);

    localparam logic [11:0] OFF_DISP  = 12'h000;
    localparam logic [11:0] OFF_TIMER = 12'h020;
    localparam logic [11:0] OFF_LED   = 12'h060;
    localparam logic [11:0] OFF_SW    = 12'h070;

    localparam int          CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_MAX = CW'(SCAN_DIV - 1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic        page_hit;
    logic [11:0] offset;

    assign page_hit = (addr[31:12] == 20'hFFFFF);
    assign offset   = addr[11:0];

    assign ram_we    = dram_we & ~page_hit;
    assign ram_addr  = addr[RAM_AW+1:2];
    assign ram_wdata = write_data;

    logic wr_disp, wr_timer, wr_led;

    assign wr_disp  = dram_we & page_hit & (offset == OFF_DISP);
    assign wr_timer = dram_we & page_hit & (offset == OFF_TIMER);
    assign wr_led   = dram_we & page_hit & (offset == OFF_LED);

    // ------------------------------------------------------------------
    // Peripheral registers
    // ------------------------------------------------------------------
    logic [31:0] disp;
    logic [31:0] timer;
    logic [23:0] sw_meta;
    logic [23:0] sw_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            disp    <= 32'h0;
            timer   <= 32'h0;
            led     <= 24'h0;
            sw_meta <= 24'h0;
            sw_sync <= 24'h0;
        end else begin
            if (wr_disp)
                disp <= write_data;
            // A store to TIMER replaces that cycle's increment.
            if (wr_timer)
                timer <= write_data;
            else
                timer <= timer + 32'd1;
            if (wr_led)
                led <= write_data[23:0];
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    // ------------------------------------------------------------------
    // Read mux: pre-edge register values, so a same-cycle store is not
    // visible until the following cycle.
    // ------------------------------------------------------------------
    always_comb begin
        read_data = ram_rdata;
        if (page_hit) begin
            case (offset)
                OFF_DISP:  read_data = disp;
                OFF_TIMER: read_data = timer;
                OFF_LED:   read_data = {8'h0, led};
                OFF_SW:    read_data = {8'h0, sw_sync};
                default:   read_data = 32'h0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [CW-1:0] scan_cnt;
    logic [2:0]    digit;
    logic [3:0]    cur_nib;
    logic [7:0]    cur_seg;

    assign cur_nib = disp[digit*4 +: 4];

    always_comb begin
        cur_seg = 8'hFF;
        case (cur_nib)
            4'h0: cur_seg = 8'hC0;
            4'h1: cur_seg = 8'hF9;
            4'h2: cur_seg = 8'hA4;
            4'h3: cur_seg = 8'hB0;
            4'h4: cur_seg = 8'h99;
            4'h5: cur_seg = 8'h92;
            4'h6: cur_seg = 8'h82;
            4'h7: cur_seg = 8'hF8;
            4'h8: cur_seg = 8'h80;
            4'h9: cur_seg = 8'h90;
            4'hA: cur_seg = 8'h88;
            4'hB: cur_seg = 8'h83;
            4'hC: cur_seg = 8'hC6;
            4'hD: cur_seg = 8'hA1;
            4'hE: cur_seg = 8'h86;
            4'hF: cur_seg = 8'h8E;
            default: cur_seg = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            digit    <= 3'd0;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt <= '0;
            digit    <= digit + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Enables and segments are registered together from the same digit
    // index, so they always switch on the same edge. Reset loads the
    // digit-0 / nibble-0 image directly, giving no blank cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_en <= 8'hFE;
            seg    <= 8'hC0;
        end else begin
            dig_en <= ~(8'b1 << digit);
            seg    <= cur_seg;
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
module tb_mmio_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        dram_we;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ram_we;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [23:0] sw;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  seg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mmio_bridge #(.RAM_AW(14), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .dram_we(dram_we), .addr(addr),
        .write_data(write_data), .read_data(read_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .sw(sw), .led(led),
        .dig_en(dig_en), .seg(seg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_seg [8];
    logic [7:0] exp_en  [8];

    initial begin
        exp_seg = '{8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        exp_en  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

        rst = 1'b1; dram_we = 1'b1; addr = 32'hFFFFF060; write_data = 32'h00FFFFFF;
        ram_rdata = 32'h0; sw = 24'h0;
        #1;

        // Reset wins over a simultaneous LED store
        tick(); tick();
        rst = 1'b0; dram_we = 1'b0; addr = 32'hFFFFF020;
        #1;
        chk("rst_led", {8'h0, led}, 32'h0);
        chk("rst_dig_en", {24'h0, dig_en}, 32'hFE);
        chk("rst_seg", {24'h0, seg}, 32'hC0);
        chk("timer_0", read_data, 32'h0);
        tick(); chk("timer_1", read_data, 32'h1);
        tick(); chk("timer_2", read_data, 32'h2);

        // RAM routing
        addr = 32'h00000010; dram_we = 1'b1; write_data = 32'h12345678; #1;
        chk("ram_we_hit", {31'h0, ram_we}, 32'h1);
        chk("ram_addr", {18'h0, ram_addr}, 32'h4);
        chk("ram_wdata", ram_wdata, 32'h12345678);
        tick();
        addr = 32'hFFFFF060; write_data = 32'h00A5A5A5; #1;
        chk("ram_we_page", {31'h0, ram_we}, 32'h0);
        chk("led_same_cycle_old", read_data, 32'h0);
        tick();
        dram_we = 1'b0; #1;
        chk("led_read", read_data, 32'h00A5A5A5);
        chk("led_port", {8'h0, led}, 32'h00A5A5A5);
        addr = 32'h00000010; ram_rdata = 32'hCAFEBABE; #1;
        chk("ram_read", read_data, 32'hCAFEBABE);
        chk("ram_we_read", {31'h0, ram_we}, 32'h0);

        // SW is read-only, unmapped offsets read 0
        addr = 32'hFFFFF070; dram_we = 1'b1; write_data = 32'hFFFFFFFF;
        tick();
        dram_we = 1'b0; #1;
        chk("sw_ro", read_data, 32'h0);
        addr = 32'hFFFFF100; dram_we = 1'b1; write_data = 32'h55AA55AA;
        tick();
        dram_we = 1'b0; #1;
        chk("unmapped", read_data, 32'h0);
        addr = 32'hFFFFF060; #1;
        chk("led_kept", read_data, 32'h00A5A5A5);

        // Switch synchronizer: two-edge lag
        addr = 32'hFFFFF070; sw = 24'h00F00F; #1;
        chk("sw_lag0", read_data, 32'h0);
        tick(); chk("sw_lag1", read_data, 32'h0);
        tick(); chk("sw_lag2", read_data, 32'h0000F00F);

        // Timer load and wrap
        addr = 32'hFFFFF020; dram_we = 1'b1; write_data = 32'hFFFFFFFE;
        tick();
        dram_we = 1'b0; #1;
        chk("timer_load", read_data, 32'hFFFFFFFE);
        tick(); chk("timer_max", read_data, 32'hFFFFFFFF);
        tick(); chk("timer_wrap", read_data, 32'h0);

        // Display scan with SCAN_DIV=4
        rst = 1'b1;
        tick();
        rst = 1'b0; addr = 32'hFFFFF000; dram_we = 1'b1; write_data = 32'hFEDCBA98; #1;
        chk("scan_rst_en", {24'h0, dig_en}, 32'hFE);
        chk("scan_rst_seg", {24'h0, seg}, 32'hC0);
        tick();
        dram_we = 1'b0; #1;
        chk("disp_read", read_data, 32'hFEDCBA98);
        // DISP landed on this edge; seg still shows the old nibble
        chk("scan_e1_en", {24'h0, dig_en}, 32'hFE);
        chk("scan_e1_seg", {24'h0, seg}, 32'hC0);
        for (int n = 2; n <= 36; n++) begin
            tick();
            chk($sformatf("scan_e%0d_en", n), {24'h0, dig_en}, {24'h0, exp_en[((n - 1) / 4) % 8]});
            chk($sformatf("scan_e%0d_seg", n), {24'h0, seg}, {24'h0, exp_seg[((n - 1) / 4) % 8]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
